// File: rtl/id_scoreboard_pkg.sv
// Shared widths and constants for the ID-stage operand scoreboard slice.
package id_scoreboard_pkg;
    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic                  ONE          = 1'b1;
    localparam logic                  ZERO         = 1'b0;
endpackage

// File: rtl/id_scoreboard_if.sv
// Handshake bundle between ID decode and the operand scoreboard.
// master = ID/pipeline side, slave = scoreboard.
interface id_scoreboard_if
    import id_scoreboard_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int RADDR_W = REG_ADDR_W,
    parameter int NUM_SRC = 2,
    parameter int NUM_BYP = 2
);
    logic [NUM_SRC-1:0]         src_rd;
    logic [NUM_SRC*RADDR_W-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0]  src_rf_data;
    logic [NUM_SRC*DATA_W-1:0]  src_imm;
    logic [NUM_SRC*DATA_W-1:0]  src_data;

    logic                       iss_valid;
    logic                       iss_wreg;
    logic [RADDR_W-1:0]         iss_wd;
    logic                       iss_long;
    logic                       iss_fire;
    logic                       stall;

    logic [NUM_BYP-1:0]         byp_valid;
    logic [NUM_BYP*RADDR_W-1:0] byp_addr;
    logic [NUM_BYP*DATA_W-1:0]  byp_data;

    logic                       cmp_valid;
    logic [RADDR_W-1:0]         cmp_addr;
    logic                       kill_valid;
    logic [RADDR_W-1:0]         kill_addr;
    logic                       sb_err;

    modport master (
        output src_rd, src_addr, src_rf_data, src_imm,
        output iss_valid, iss_wreg, iss_wd, iss_long,
        output byp_valid, byp_addr, byp_data,
        output cmp_valid, cmp_addr, kill_valid, kill_addr,
        input  src_data, iss_fire, stall, sb_err
    );

    modport slave (
        input  src_rd, src_addr, src_rf_data, src_imm,
        input  iss_valid, iss_wreg, iss_wd, iss_long,
        input  byp_valid, byp_addr, byp_data,
        input  cmp_valid, cmp_addr, kill_valid, kill_addr,
        output src_data, iss_fire, stall, sb_err
    );
endinterface

// File: rtl/id_byp_mux.sv
// One operand resolver: immediate, hard-wired zero register, priority bypass
// (port 0 = youngest wins), otherwise regfile data.
module id_byp_mux
    import id_scoreboard_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int RADDR_W = REG_ADDR_W,
    parameter int NUM_BYP = 2
) (
    input  logic                       i_rd,
    input  logic [RADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]          i_rf_data,
    input  logic [DATA_W-1:0]          i_imm,
    input  logic [NUM_BYP-1:0]         i_byp_valid,
    input  logic [NUM_BYP*RADDR_W-1:0] i_byp_addr,
    input  logic [NUM_BYP*DATA_W-1:0]  i_byp_data,
    output logic [DATA_W-1:0]          o_data
);
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;

    always_comb begin
        w_hit = 1'b0;
        w_byp = i_rf_data;
        for (int unsigned j = 0; j < NUM_BYP; j++) begin
            if (!w_hit && i_byp_valid[j] && i_byp_addr[j*RADDR_W +: RADDR_W] == i_addr) begin
                w_hit = 1'b1;
                w_byp = i_byp_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (!i_rd)
            o_data = i_imm;
        else if (i_addr == RADDR_W'(NOP_REG_ADDR))
            o_data = DATA_W'(ZERO_WORD);
        else
            o_data = w_byp;
    end
endmodule

// File: rtl/id_scoreboard.sv
// ID-stage operand hazard unit: per-register pending-writer counters, stall/err logic,
// and one id_byp_mux per source operand. Define ID_SB_STATS_EN to add the stall_cnt port.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int RADDR_W = REG_ADDR_W,
    parameter int NUM_SRC = 2,
    parameter int NUM_BYP = 2,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    id_scoreboard_if.slave    bus
`ifdef ID_SB_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int NUM_REGS = 1 << RADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   r_cnt [NUM_REGS];
    logic               r_sb_err;
    logic [RADDR_W-1:0] w_src_addr [NUM_SRC];
    logic [NUM_REGS-1:0] w_err_set;
    logic               w_hazard;
    logic               w_waw_full;
    logic               w_stall;
    logic               w_fire;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign w_src_addr[s] = bus.src_addr[s*RADDR_W +: RADDR_W];

        id_byp_mux #(
            .DATA_W  (DATA_W),
            .RADDR_W (RADDR_W),
            .NUM_BYP (NUM_BYP)
        ) u_mux (
            .i_rd        (bus.src_rd[s]),
            .i_addr      (w_src_addr[s]),
            .i_rf_data   (bus.src_rf_data[s*DATA_W +: DATA_W]),
            .i_imm       (bus.src_imm[s*DATA_W +: DATA_W]),
            .i_byp_valid (bus.byp_valid),
            .i_byp_addr  (bus.byp_addr),
            .i_byp_data  (bus.byp_data),
            .o_data      (bus.src_data[s*DATA_W +: DATA_W])
        );
    end

    // A completion this cycle releases the hazard; its data arrives via a bypass port.
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.src_rd[i] && w_src_addr[i] != RADDR_W'(NOP_REG_ADDR) &&
                r_cnt[w_src_addr[i]] != '0 &&
                !(bus.cmp_valid && bus.cmp_addr == w_src_addr[i]))
                w_hazard = 1'b1;
        end
    end

    assign w_waw_full = bus.iss_wreg && bus.iss_long && r_cnt[bus.iss_wd] == CNT_MAX;
    assign w_stall    = bus.iss_valid && (w_hazard || w_waw_full);
    assign w_fire     = bus.iss_valid && !w_stall;

    assign bus.stall    = w_stall;
    assign bus.iss_fire = w_fire;
    assign bus.sb_err   = r_sb_err;

    // Net change per register; two extra bits keep cnt+inc-dec from wrapping.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic             w_inc;
        logic [CNT_W+1:0] w_sum;
        logic [CNT_W+1:0] w_dec;

        assign w_inc = w_fire && bus.iss_wreg && bus.iss_long &&
                       bus.iss_wd == RADDR_W'(g) && (g != 0);
        assign w_sum = (CNT_W+2)'(r_cnt[g]) + (CNT_W+2)'(w_inc);
        assign w_dec = (CNT_W+2)'(bus.cmp_valid && bus.cmp_addr == RADDR_W'(g)) +
                       (CNT_W+2)'(bus.kill_valid && bus.kill_addr == RADDR_W'(g));
        assign w_err_set[g] = w_dec > w_sum;

        always_ff @(posedge clk) begin
            if (rst || g == 0 || w_err_set[g])
                r_cnt[g] <= '0;
            else
                r_cnt[g] <= CNT_W'(w_sum - w_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_sb_err <= ZERO;
        else if (|w_err_set)
            r_sb_err <= ONE;
    end

`ifdef ID_SB_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
